// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and frame constants
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an idle-high asynchronous input
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic sync
);

  logic meta;

  // Both stages reset high so an idle line never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= line;
      sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW   = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  logic                      sync;
  uart_state_t               state;
  uart_state_t               state_next;
  logic [CW-1:0]             count;
  logic [CW-1:0]             count_next;
  logic [IW-1:0]             index;
  logic [UART_DATA_BITS-1:0] r_Rx_Data;
  logic                      bit_tick;
  logic                      rx_bit;
  logic                      dv_set;
  logic                      err_set;
  logic                      active_set;
  logic                      active_clr;

  uart_rx_sync u_sync (
    .clk   (i_Clock),
    .rst_n (i_Reset_n),
    .line  (i_Rx_Serial),
    .sync  (sync)
  );

  generate
    if (CLKS_PER_BIT < 2) begin : g_cpb_min
      $error("uart_rx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  // Last clock of a data or stop bit period: the decision point for that bit
  assign bit_tick = ((state == DATA) || (state == STOP)) && (count == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  generate
    if (CLKS_PER_BIT < 4) begin : g_cpb_vote
      $error("uart_rx: majority sampling needs CLKS_PER_BIT of at least 4");
    end
  endgenerate

  localparam logic [CW-1:0] CNT_VOTE_A = CW'(CLKS_PER_BIT - 3);
  localparam logic [CW-1:0] CNT_VOTE_B = CW'(CLKS_PER_BIT - 2);

  logic vote_a;
  logic vote_b;

  // Hold the two early votes of each bit; the third is the live sample
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if ((state == DATA) || (state == STOP)) begin
      if (count == CNT_VOTE_A) vote_a <= sync;
      if (count == CNT_VOTE_B) vote_b <= sync;
    end
  end

  assign rx_bit = (vote_a & vote_b) | (vote_a & sync) | (vote_b & sync);
`else
  assign rx_bit = sync;
`endif

  // State register
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!sync) state_next = START;
      START:     if (count == CNT_HALF) state_next = sync ? IDLE : DATA;
      DATA:      if (bit_tick && (index == IDX_LAST)) state_next = STOP;
      STOP:      if (bit_tick) state_next = rx_bit ? CLEANUP : WAIT_IDLE;
      CLEANUP:   state_next = IDLE;
      WAIT_IDLE: if (sync) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output and counter decode; the counter restarts on every state change
  always_comb begin
    count_next = '0;
    if (state_next == state) begin
      case (state)
        START:      count_next = count + CW'(1);
        DATA, STOP: count_next = (count == CNT_LAST) ? '0 : count + CW'(1);
        default:    count_next = '0;
      endcase
    end
    active_set = (state == START) && (count == CNT_HALF) && !sync;
    active_clr = (state == STOP) && bit_tick;
    dv_set     = (state == STOP) && bit_tick && rx_bit;
    err_set    = (state == STOP) && bit_tick && !rx_bit;
  end

  // Datapath and registered outputs
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count          <= '0;
      index          <= '0;
      r_Rx_Data      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active    <= 1'b0;
      o_Rx_Byte      <= 8'h00;
    end else begin
      count <= count_next;
      if (state == DATA) begin
        if (bit_tick) begin
          r_Rx_Data[index] <= rx_bit;
          if (index != IDX_LAST) index <= index + IW'(1);
        end
      end else begin
        index <= '0;
      end
      o_Rx_DV        <= dv_set;
      o_Rx_Frame_Err <= err_set;
      if (dv_set) o_Rx_Byte <= r_Rx_Data;
      if (active_set)      o_Rx_Active <= 1'b1;
      else if (active_clr) o_Rx_Active <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of the team's `uart_tx`. It samples an 8N1 line (1 start, 8 data bits LSB-first, 1 stop) at `CLKS_PER_BIT` clocks per bit. It synchronises the line into the `i_Clock` domain, rejects glitch start bits, and presents each received byte with a one-cycle valid strobe. It sits between the board UART pin and the command/host-link logic.

## Interface
- `CLKS_PER_BIT`, default 2 — clocks per bit. Minimum 2; minimum 4 when majority sampling is compiled in.
- `i_Clock` in 1 — sole clock, rising edge.
- `i_Reset_n` in 1 — asynchronous, active-low reset.
- `i_Rx_Serial` in 1 — serial line, asynchronous to `i_Clock`, idle high.
- `o_Rx_DV` out 1 — one-cycle pulse when a byte with a valid stop bit is received.
- `o_Rx_Byte` out 8 — last good byte; updated only together with `o_Rx_DV`.
- `o_Rx_Frame_Err` out 1 — one-cycle pulse when the stop bit is sampled low.
- `o_Rx_Active` out 1 — high from start-bit acceptance until the stop-bit decision.

## Operation
- Synchroniser: two flops, both reset to 1. All logic uses stage-2 (`sync`) only.
- Derived value: `HALF = (CLKS_PER_BIT-1)/2` (integer). The counter is `$clog2(CLKS_PER_BIT)` bits wide and is zeroed on every state change.
- `IDLE`
  - Counter and bit index are 0.
  - If `sync`==0 → `START`.
- `START`
  - Count up to `HALF`.
  - At count==`HALF`: if `sync`==0, set `o_Rx_Active`, zero the counter, and go to `DATA`.
  - Otherwise (glitch) → `IDLE` with no output.
- `DATA`
  - At count==`CLKS_PER_BIT-1`, sample the bit into `r_Rx_Data[index]`.
  - Indices 0–6: increment the index.
  - Index 7: → `STOP`.
- `STOP` — at count==`CLKS_PER_BIT-1`, clear `o_Rx_Active` and sample the stop bit:
  - Stop bit 1: load `o_Rx_Byte` with `r_Rx_Data`, pulse `o_Rx_DV`, → `CLEANUP`.
  - Stop bit 0: pulse `o_Rx_Frame_Err`, leave `o_Rx_Byte` unchanged, → `WAIT_IDLE`.
- `CLEANUP` — one cycle, → `IDLE`.
- `WAIT_IDLE` — remain until `sync`==1, then → `IDLE`. A line held low (break) produces exactly one frame error, not a stream of them.
- Undefined state encodings → `IDLE`.
- Reset, asynchronous and possible mid-frame:
  - State → `IDLE`; counter, index and `r_Rx_Data` → 0.
  - `o_Rx_DV`, `o_Rx_Frame_Err`, `o_Rx_Active` → 0; `o_Rx_Byte` → 0x00.
  - Synchroniser flops → 1.
  - A partial frame is discarded. Reception resumes at the next falling edge seen after reset release.
- No input flow control. A byte is overwritten by the next one; the consumer must take `o_Rx_Byte` on `o_Rx_DV`.

## Timing
- Define edge 0 as the first `i_Clock` rising edge at which synchroniser stage 1 captures the start-bit low.
- `o_Rx_DV` (or `o_Rx_Frame_Err`) is high during the cycle after edge `3 + HALF + 9*CLKS_PER_BIT`.
  - `CLKS_PER_BIT`=4: edge 40.
  - `CLKS_PER_BIT`=2: edge 21.
- `o_Rx_Active` rises after edge `3 + HALF` and falls in the same cycle as the strobe.
- Back-to-back frames driven by `uart_tx` with the same `CLKS_PER_BIT` are received without loss. The next start edge is recognised in `IDLE` after the single `CLEANUP` cycle.
- `o_Rx_DV` and `o_Rx_Frame_Err` are never high in the same cycle.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Each data and stop bit is the 2-of-3 majority of `sync` at counts `CLKS_PER_BIT-3`, `CLKS_PER_BIT-2` and `CLKS_PER_BIT-1`.
  - The first two samples are registered; the vote is combinational at count `CLKS_PER_BIT-1`, so latency is unchanged.
  - An elaboration-time error fires if `CLKS_PER_BIT` < 4.
  - Start-bit validation stays single-sample.
- Undefined: single sample at count `CLKS_PER_BIT-1`; the two sample registers are not present.

## Structure
- Shared package `uart_pkg`:
  - State encodings: `IDLE`, `START`, `DATA`, `STOP`, `CLEANUP`, `WAIT_IDLE`, 3 bits.
  - `UART_DATA_BITS` = 8.
  - Shared with the transmitter.
- One sub-module, `uart_rx_sync`: the two-flop synchroniser with reset value 1, reusable on other asynchronous inputs.
- All remaining logic (state machine, counter, shift register, vote) lives in `uart_rx`.

## Test plan
- **Good frame:** `CLKS_PER_BIT`=4, drive 0xA5 as 8N1 → `o_Rx_DV` one cycle at edge 40, `o_Rx_Byte`=0xA5, `o_Rx_Frame_Err`=0.
- **Loopback:** `uart_tx` → `uart_rx` loopback, bytes 0x00, 0xFF, 0x55, 0x3C back-to-back → four `o_Rx_DV` pulses in order with matching bytes, no errors.
- **Glitch start:** low pulse of 1 clock (shorter than `HALF+1`) on an idle line → no `o_Rx_Active`, no strobes, state returns to `IDLE`.
- **Framing error and break:** 0x12 with stop bit 0, line then held low 100 clocks → exactly one `o_Rx_Frame_Err` pulse, `o_Rx_Byte` keeps its previous value. Release the line, send 0x34 → `o_Rx_DV` with 0x34.
- **Reset mid-frame:** assert `i_Reset_n`=0 during data bit 3 → all outputs 0 immediately. After release, a full 0x7E frame → `o_Rx_DV` with 0x7E.
- **Majority sampling** (with `UART_RX_MAJORITY_EN`, `CLKS_PER_BIT`=8): send 0xF0 with a 1-clock inverted glitch at count 6 of every bit → `o_Rx_Byte`=0xF0, no errors.
